// File: rtl/btn_log_pkg.sv
// Shared types, widths and full-policy constants for the button event logger.
package btn_log_pkg;

  localparam int WRAP_STOP      = 0;
  localparam int WRAP_OVERWRITE = 1;

  // Widest record the logger can produce: up to 16 channels and 32-bit timestamps.
  localparam int REC_CH_MAX = 4;
  localparam int REC_TS_MAX = 32;

  typedef struct packed {
    logic [REC_CH_MAX-1:0] channel;
    logic [REC_TS_MAX-1:0] timestamp;
  } btn_rec_t;

  function automatic int ch_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  function automatic int rec_width(input int n_btn, input int ts_w);
    return ch_width(n_btn) + ts_w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter and a
// single-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEB_CYC-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST_CNT) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/btn_event_logger.sv
// Debounced multi-button press logger: timestamps each press, arbitrates
// lowest channel first into a circular record buffer drained by the host.
module btn_event_logger
  import btn_log_pkg::*;
#(
  parameter int N_BTN   = 4,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 12,
  parameter int DEB_CYC = 4,
  parameter int WRAP    = WRAP_STOP
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_BTN-1:0]                  button,
  input  logic                              rd_en,
  input  logic                              clr_ovf,
  output logic [rec_width(N_BTN, TS_W)-1:0] rd_data,
  output logic                              rd_valid,
  output logic                              mem_full,
  output logic                              mem_empty,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              overflow
);

  localparam int CH_W  = ch_width(N_BTN);
  localparam int REC_W = rec_width(N_BTN, TS_W);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [N_BTN-1:0] rise;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (button[g]),
      .rise_o (rise[g])
    );
  end

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  tsHold_q [N_BTN];
  logic [N_BTN-1:0] pending_q, pending_d, grant;
  logic [CH_W-1:0]  wrCh;
  logic             anyPending, isFull, doWrite, doRead, overwrite;
  logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] wrData, rdData_q, rdData_d;
  logic             rdValid_q, full_q, empty_q, ovf_q, ovf_d;

  always_comb begin
    grant      = '0;
    wrCh       = '0;
    anyPending = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant      = '0;
        grant[i]   = 1'b1;
        wrCh       = CH_W'(i);
        anyPending = 1'b1;
      end
    end
  end

  // All decisions use the pre-edge count, so a write into an empty buffer
  // never reads through in the same cycle.
  always_comb begin
    isFull    = (count_q == FULL_CNT);
    doRead    = rd_en && (count_q != '0);
    doWrite   = anyPending && (!isFull || (WRAP == WRAP_OVERWRITE));
    overwrite = doWrite && isFull;
    wrData    = {wrCh, tsHold_q[wrCh]};

    pending_d = (pending_q & ~(doWrite ? grant : '0)) | (rise & ~pending_q);

    count_d = count_q;
    if (!overwrite) begin
      if (doWrite && !doRead)      count_d = count_q + 1'b1;
      else if (doRead && !doWrite) count_d = count_q - 1'b1;
    end

    wrPtr_d = doWrite ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = (doRead || overwrite) ? rdPtr_q + 1'b1 : rdPtr_q;
    rdData_d = doRead ? mem_q[rdPtr_q] : rdData_q;
    ovf_d    = (ovf_q & ~clr_ovf) | overwrite | (|(rise & pending_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q      <= '0;
      pending_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) tsHold_q[i] <= '0;
    end else begin
      ts_q      <= ts_q + 1'b1;
      pending_q <= pending_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rdData_q  <= rdData_d;
      rdValid_q <= doRead;
      full_q    <= (count_d == FULL_CNT);
      empty_q   <= (count_d == '0);
      ovf_q     <= ovf_d;
      for (int i = 0; i < N_BTN; i++) begin
        if (rise[i] && !pending_q[i]) tsHold_q[i] <= ts_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && doWrite) mem_q[wrPtr_q] <= wrData;
  end

  assign rd_data   = rdData_q;
  assign rd_valid  = rdValid_q;
  assign mem_full  = full_q;
  assign mem_empty = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_event_logger.sv
// Scoreboard bench: dut0 uses the stop-when-full policy, dut1 overwrites the oldest record.
module tb_btn_event_logger;
  import btn_log_pkg::*;

  localparam int N_BTN   = 4;
  localparam int DEPTH   = 16;
  localparam int TS_W    = 12;
  localparam int DEB_CYC = 4;
  localparam int CH_W    = ch_width(N_BTN);
  localparam int REC_W   = rec_width(N_BTN, TS_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] button0 = '0, button1 = '0;
  logic             rdEn0 = 1'b0, rdEn1 = 1'b0, clrOvf0 = 1'b0, clrOvf1 = 1'b0;
  logic [REC_W-1:0] rdData0, rdData1;
  logic             rdValid0, rdValid1, full0, full1, empty0, empty1, ovf0, ovf1;
  logic [CNT_W-1:0] count0, count1;

  int tests = 0;
  int fails = 0;
  logic [TS_W-1:0] tbTs = '0;
  btn_rec_t exp0[$];
  btn_rec_t exp1[$];

  always #5 clk = ~clk;

  // Reference timestamp, mirrors the free-running counter's reset behaviour.
  always @(posedge clk) tbTs <= rst ? '0 : tbTs + 1'b1;

  btn_event_logger #(.N_BTN(N_BTN), .DEPTH(DEPTH), .TS_W(TS_W), .DEB_CYC(DEB_CYC),
                     .WRAP(WRAP_STOP)) u_dut0 (
    .clk(clk), .rst(rst), .button(button0), .rd_en(rdEn0), .clr_ovf(clrOvf0),
    .rd_data(rdData0), .rd_valid(rdValid0), .mem_full(full0), .mem_empty(empty0),
    .count(count0), .overflow(ovf0)
  );

  btn_event_logger #(.N_BTN(N_BTN), .DEPTH(DEPTH), .TS_W(TS_W), .DEB_CYC(DEB_CYC),
                     .WRAP(WRAP_OVERWRITE)) u_dut1 (
    .clk(clk), .rst(rst), .button(button1), .rd_en(rdEn1), .clr_ovf(clrOvf1),
    .rd_data(rdData1), .rd_valid(rdValid1), .mem_full(full1), .mem_empty(empty1),
    .count(count1), .overflow(ovf1)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A press driven now is captured with the timestamp DEB_CYC+2 cycles later.
  task automatic pushRec(input int which, input int ch);
    btn_rec_t r;
    r = '0;
    r.channel   = 4'(ch);
    r.timestamp = 32'(tbTs + TS_W'(2 + DEB_CYC));
    if (which == 0) exp0.push_back(r);
    else begin
      if (exp1.size() == DEPTH) exp1.delete(0);
      exp1.push_back(r);
    end
  endtask

  function automatic logic [REC_W-1:0] popExp(input int which);
    btn_rec_t r;
    r = '0;
    if (which == 0) begin
      if (exp0.size() > 0) r = exp0.pop_front();
    end else if (exp1.size() > 0) r = exp1.pop_front();
    return {r.channel[CH_W-1:0], r.timestamp[TS_W-1:0]};
  endfunction

  task automatic applyStimulus(input int which, input logic [N_BTN-1:0] mask,
                               input bit logged, input int hold, input int gap);
    if (logged) for (int ch = 0; ch < N_BTN; ch++) if (mask[ch]) pushRec(which, ch);
    if (which == 0) button0 = mask; else button1 = mask;
    tick(hold);
    if (which == 0) button0 = '0; else button1 = '0;
    tick(gap);
  endtask

  task automatic rdPulse(input int which, output logic v, output logic [REC_W-1:0] d);
    if (which == 0) rdEn0 = 1'b1; else rdEn1 = 1'b1;
    tick(1);
    v = (which == 0) ? rdValid0 : rdValid1;
    d = (which == 0) ? rdData0 : rdData1;
    rdEn0 = 1'b0;
    rdEn1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [REC_W+CNT_W+3:0] got0, got1, want;
    rst = 1'b1;
    tick(2);
    want = {{REC_W{1'b0}}, 1'b0, 1'b0, 1'b1, {CNT_W{1'b0}}, 1'b0};
    got0 = {rdData0, rdValid0, full0, empty0, count0, ovf0};
    got1 = {rdData1, rdValid1, full1, empty1, count1, ovf1};
    tests++;
    if (got0 !== want) begin
      fails++; $display("[TB] FAIL reset_dut0: got %h, want %h", got0, want);
    end
    tests++;
    if (got1 !== want) begin
      fails++; $display("[TB] FAIL reset_dut1: got %h, want %h", got1, want);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_press();
    logic v;
    logic [REC_W-1:0] d, want;
    pushRec(0, 2);
    button0 = 4'b0100;
    tick(7);
    tests++;
    if (count0 !== CNT_W'(0)) begin
      fails++; $display("[TB] FAIL single_early_count: got %0d, want 0", count0);
    end
    tick(1);
    tests++;
    if (count0 !== CNT_W'(1) || empty0 !== 1'b0) begin
      fails++; $display("[TB] FAIL single_write: got count %0d empty %b, want 1 0", count0, empty0);
    end
    tick(2);
    button0 = '0;
    tick(10);
    want = popExp(0);
    rdPulse(0, v, d);
    tests++;
    if (v !== 1'b1 || d !== want) begin
      fails++; $display("[TB] FAIL single_read: got valid %b data %h, want 1 %h", v, d, want);
    end
    tests++;
    if (count0 !== CNT_W'(0) || empty0 !== 1'b1) begin
      fails++; $display("[TB] FAIL single_drained: got count %0d empty %b, want 0 1", count0, empty0);
    end
    tick(1);
    tests++;
    if (rdValid0 !== 1'b0 || rdData0 !== want) begin
      fails++; $display("[TB] FAIL single_hold: got valid %b data %h, want 0 %h", rdValid0, rdData0, want);
    end
  endtask

  task automatic test_glitch();
    button0 = 4'b0001;
    tick(3);
    button0 = '0;
    tick(12);
    tests++;
    if (count0 !== CNT_W'(0) || empty0 !== 1'b1) begin
      fails++; $display("[TB] FAIL glitch_rejected: got count %0d empty %b, want 0 1", count0, empty0);
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [REC_W-1:0] d, want;
    pushRec(0, 0);
    pushRec(0, 1);
    pushRec(0, 3);
    button0 = 4'b1011;
    tick(8);
    for (int k = 1; k <= 3; k++) begin
      tests++;
      if (count0 !== CNT_W'(k)) begin
        fails++; $display("[TB] FAIL simul_count_%0d: got %0d, want %0d", k, count0, k);
      end
      if (k < 3) tick(1);
    end
    tick(2);
    button0 = '0;
    tick(10);
    want = '0;
    rdEn0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      want = popExp(0);
      tests++;
      if (rdValid0 !== 1'b1 || rdData0 !== want) begin
        fails++; $display("[TB] FAIL simul_read_%0d: got valid %b data %h, want 1 %h", k, rdValid0, rdData0, want);
      end
    end
    rdEn0 = 1'b0;
    tests++;
    if (count0 !== CNT_W'(0) || empty0 !== 1'b1) begin
      fails++; $display("[TB] FAIL simul_drained: got count %0d empty %b, want 0 1", count0, empty0);
    end
    rdPulse(0, v, d);
    tests++;
    if (v !== 1'b0 || d !== want) begin
      fails++; $display("[TB] FAIL empty_read_ignored: got valid %b data %h, want 0 %h", v, d, want);
    end
  endtask

  task automatic test_full_stop();
    logic v;
    logic [REC_W-1:0] d, want;
    for (int i = 0; i < 16; i++) applyStimulus(0, N_BTN'(1 << (i % N_BTN)), 1'b1, 8, 8);
    tests++;
    if (full0 !== 1'b1 || count0 !== CNT_W'(16) || ovf0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_full: got full %b count %0d ovf %b, want 1 16 0", full0, count0, ovf0);
    end
    applyStimulus(0, 4'b0001, 1'b1, 8, 8);
    tests++;
    if (count0 !== CNT_W'(16) || ovf0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_17th_pending: got count %0d ovf %b, want 16 0", count0, ovf0);
    end
    want = popExp(0);
    rdPulse(0, v, d);
    tests++;
    if (v !== 1'b1 || d !== want || count0 !== CNT_W'(15) || full0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_read: got valid %b data %h count %0d full %b, want 1 %h 15 0", v, d, count0, full0, want);
    end
    tick(1);
    tests++;
    if (count0 !== CNT_W'(16) || full0 !== 1'b1 || ovf0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_refill: got count %0d full %b ovf %b, want 16 1 0", count0, full0, ovf0);
    end
    applyStimulus(0, 4'b0001, 1'b1, 8, 8);
    tests++;
    if (ovf0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_pending_no_ovf: got %b, want 0", ovf0);
    end
    applyStimulus(0, 4'b0001, 1'b0, 8, 8);
    tests++;
    if (ovf0 !== 1'b1) begin
      fails++; $display("[TB] FAIL stop_retrigger_ovf: got %b, want 1", ovf0);
    end
    clrOvf0 = 1'b1;
    tick(1);
    clrOvf0 = 1'b0;
    tests++;
    if (ovf0 !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_clr_ovf: got %b, want 0", ovf0);
    end
    rdEn0 = 1'b1;
    for (int k = 0; k < 40 && exp0.size() > 0; k++) begin
      tick(1);
      want = popExp(0);
      tests++;
      if (rdValid0 !== 1'b1 || rdData0 !== want) begin
        fails++; $display("[TB] FAIL stop_drain_%0d: got valid %b data %h, want 1 %h", k, rdValid0, rdData0, want);
      end
    end
    rdEn0 = 1'b0;
    tick(1);
    tests++;
    if (empty0 !== 1'b1 || count0 !== CNT_W'(0)) begin
      fails++; $display("[TB] FAIL stop_drained: got empty %b count %0d, want 1 0", empty0, count0);
    end
  endtask

  task automatic test_wrap();
    logic v;
    logic [REC_W-1:0] d, want;
    for (int i = 0; i < 16; i++) applyStimulus(1, N_BTN'(1 << (i % N_BTN)), 1'b1, 8, 8);
    tests++;
    if (full1 !== 1'b1 || count1 !== CNT_W'(16) || ovf1 !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_full: got full %b count %0d ovf %b, want 1 16 0", full1, count1, ovf1);
    end
    for (int i = 16; i < 18; i++) applyStimulus(1, N_BTN'(1 << (i % N_BTN)), 1'b1, 8, 8);
    tests++;
    if (count1 !== CNT_W'(16) || ovf1 !== 1'b1 || full1 !== 1'b1) begin
      fails++; $display("[TB] FAIL wrap_overwrite: got count %0d ovf %b full %b, want 16 1 1", count1, ovf1, full1);
    end
    want = popExp(1);
    rdPulse(1, v, d);
    tests++;
    if (v !== 1'b1 || d !== want) begin
      fails++; $display("[TB] FAIL wrap_oldest: got valid %b data %h, want 1 %h", v, d, want);
    end
    clrOvf1 = 1'b1;
    tick(1);
    clrOvf1 = 1'b0;
    tests++;
    if (ovf1 !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_clr_ovf: got %b, want 0", ovf1);
    end
    rdEn1 = 1'b1;
    for (int k = 0; k < 40 && exp1.size() > 0; k++) begin
      tick(1);
      want = popExp(1);
      tests++;
      if (rdValid1 !== 1'b1 || rdData1 !== want) begin
        fails++; $display("[TB] FAIL wrap_drain_%0d: got valid %b data %h, want 1 %h", k, rdValid1, rdData1, want);
      end
    end
    rdEn1 = 1'b0;
    tests++;
    if (empty1 !== 1'b1 || count1 !== CNT_W'(0)) begin
      fails++; $display("[TB] FAIL wrap_drained: got empty %b count %0d, want 1 0", empty1, count1);
    end
  endtask

  task automatic test_mid_reset();
    logic v;
    logic [REC_W-1:0] d;
    button0 = 4'b0111;
    tick(7);
    rst = 1'b1;
    button0 = '0;
    tick(1);
    tests++;
    if (count0 !== CNT_W'(0) || empty0 !== 1'b1 || full0 !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_clear: got count %0d empty %b full %b, want 0 1 0", count0, empty0, full0);
    end
    rst = 1'b0;
    tick(15);
    tests++;
    if (count0 !== CNT_W'(0) || empty0 !== 1'b1) begin
      fails++; $display("[TB] FAIL midreset_no_write: got count %0d empty %b, want 0 1", count0, empty0);
    end
    rdPulse(0, v, d);
    tests++;
    if (v !== 1'b0 || d !== {REC_W{1'b0}}) begin
      fails++; $display("[TB] FAIL midreset_read: got valid %b data %h, want 0 0", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_full_stop();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_event_logger.md
# btn_event_logger

Parametrised successor to the single-button capture datapath: debounces `N_BTN` push-buttons and detects each press. Each press is logged as a timestamped record in a `DEPTH`-entry on-chip buffer, which a host drains through a read port. It adds debouncing, multi-channel arbitration, a selectable stop-or-overwrite full policy, and overflow reporting. It sits between the board button pins and the readout/UART logic.

## Interface
- `N_BTN`, 4: number of button channels, 1..16
- `DEPTH`, 16: record buffer entries, power of two, ≥2
- `TS_W`, 12: timestamp width
- `DEB_CYC`, 4: consecutive stable cycles required to accept a level change, ≥1
- `WRAP`, 0: full policy (0 = stop writing, 1 = overwrite oldest)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `button` in `N_BTN`: raw asynchronous button levels, active-high
- `rd_en` in 1: pop request; ignored when `mem_empty`
- `clr_ovf` in 1: clears `overflow`
- `rd_data` out `CH_W+TS_W`: `{channel, timestamp}`, `CH_W = max(1,$clog2(N_BTN))`
- `rd_valid` out 1: `rd_data` valid, one-cycle pulse
- `mem_full` out 1: count == `DEPTH`
- `mem_empty` out 1: count == 0
- `count` out `$clog2(DEPTH)+1`: stored records
- `overflow` out 1: sticky, at least one event lost or overwritten

## Operation
- **Reset values:**
  - `rd_data`=0, `rd_valid`=0, `mem_full`=0, `mem_empty`=1, `count`=0, `overflow`=0.
  - Pointers, pending bits, timestamp and debounce counters are 0.
  - Debounced levels are 0.
  - Buffer contents are don't-care.
- **Synchronise:** two flops per channel.
- **Debounce:**
  - A per-channel counter counts cycles where the synchronised level ≠ debounced level, and resets to 0 on agreement.
  - When the counter reaches `DEB_CYC`, the debounced level flips and the counter clears.
- **Edge detection:** a 0→1 transition of the debounced level sets `pending[ch]`. Releases are not logged.
- **Timestamp:** free-running `TS_W` counter, +1 every cycle, wraps to 0. A record captures the value on the cycle `pending` is set; it is held per channel.
- **Arbiter:** each cycle the lowest-index set `pending` is written if the write is permitted. Its pending bit clears on the same edge. At most one write per cycle.
- **Re-trigger while pending:** a new rising edge on a channel whose `pending` is still set is dropped and sets `overflow`.
- **Full, `WRAP`=0:** no write. Pending bits are retained until space frees.
- **Full, `WRAP`=1:**
  - The write overwrites the oldest entry, the read pointer advances, `count` stays `DEPTH`, and `overflow` is set.
  - With simultaneous `rd_en`, the read returns the oldest entry and the write proceeds. The read pointer advances once only.
- **Read:** on `rd_en` with `mem_empty`=0, the entry at the read pointer is registered to `rd_data` and `rd_valid`=1 the next cycle. `rd_data` holds its value otherwise.
- **Count:**
  - Write+read in the same cycle leaves `count` unchanged.
  - A read on an empty buffer is ignored.
  - A write into an empty buffer together with `rd_en` does not read through; the empty check uses the pre-edge count.
- **`overflow` update:** `clr_ovf` and a new overflow event in the same cycle leave `overflow`=1.
- **Reset mid-operation:** reset clears all state in one edge, discarding pending events and buffer contents.

## Timing
- A raw press held stable at edge t:
  - Synchronised level at t+2.
  - Debounced level at t+2+`DEB_CYC`.
  - `pending` at t+3+`DEB_CYC`.
  - Buffer write and `count`/flags update at t+4+`DEB_CYC`, if uncontested.
- Glitches shorter than `DEB_CYC` cycles after synchronisation are rejected.
- Read latency is 1 cycle from `rd_en` to `rd_valid`.
- Flags are registered and consistent with `count` on every edge.
- Sustained throughput is 1 record/cycle. k simultaneous presses are written over k consecutive cycles, lowest index first.

## Structure
- **Package `btn_log_pkg`:**
  - `CH_W`/record-width functions.
  - Record typedef (`channel`, `timestamp`) as a packed struct.
  - `WRAP` mode constants `WRAP_STOP`/`WRAP_OVERWRITE`.
- **Sub-module `btn_debounce`:** one channel of synchroniser, counter and rising-edge pulse, parametrised by `DEB_CYC`. Instantiated `N_BTN` times via generate.
- **Top:** timestamp counter, pending/arbiter, buffer array, pointers, count and flags.

## Test plan
- Defaults: ch2 pressed and held 10 cycles from edge 5 → one record `{2, ts}` with `count`=1. The write lands at edge 5+4+`DEB_CYC`; `rd_en` then returns it with `rd_valid` 1 cycle later and `count`=0.
- 3-cycle glitch on ch0 with `DEB_CYC`=4 → no record, `count` stays 0.
- ch3, ch1, ch0 pressed on the same edge → records read back in order ch0, ch1, ch3 on consecutive write cycles, with timestamps all equal.
- `WRAP`=0, 17 sequential presses, `DEPTH`=16 → `mem_full`=1 at 16 and the 17th stays pending. Then one read → the 17th is written, `count`=16, `overflow`=0. A re-press of that channel while pending sets `overflow`=1.
- `WRAP`=1, 18 presses → `count`=16, `overflow`=1, and the first read returns the 3rd record. `clr_ovf` → 0.
- Assert `rst` mid-burst with 3 pending → next edge `count`=0, `mem_empty`=1, and no further writes.
